// File: rtl/alarm_sounder_if.sv
// Signal bundle between the alarm/time logic, the buttons and the piezo driver.
// The master side drives the match level, the seconds tick and the buttons;
// the slave side (alarm_sounder) drives the piezo and status outputs.
interface alarm_sounder_if;
    logic hit;
    logic sec_tick;
    logic b_stop;
    logic b_snooze;
    logic piezo;
    logic ringing;
    logic snoozed;

    modport master (
        output hit,
        output sec_tick,
        output b_stop,
        output b_snooze,
        input  piezo,
        input  ringing,
        input  snoozed
    );

    modport slave (
        input  hit,
        input  sec_tick,
        input  b_stop,
        input  b_snooze,
        output piezo,
        output ringing,
        output snoozed
    );
endinterface

// File: rtl/alarm_sounder.sv
// alarm_sounder: turns the alarm-match level into a gated square-wave piezo
// drive with a beep cadence, stop/snooze handling and a ring timeout.
// Optional feature macro: SNOOZE_EN. When it is defined, the SNOOZE state and
// snooze counter are built. When it is undefined, b_snooze is ignored and
// snoozed is held at 0.
module alarm_sounder #(
    parameter int TONE_HALF   = 12500,
    parameter int BEEP_CYC    = 25000000,
    parameter int SNOOZE_SEC  = 300,
    parameter int TIMEOUT_SEC = 60
) (
    input  logic           clk,
    input  logic           reset,
    alarm_sounder_if.slave bus
);

    localparam logic [15:0] LP_TONE_LAST = 16'(TONE_HALF - 1);
    localparam logic [24:0] LP_BEEP_LAST = 25'(BEEP_CYC - 1);
    localparam logic [8:0]  LP_TIMEOUT   = 9'(TIMEOUT_SEC);

`ifdef SNOOZE_EN
    localparam logic [8:0]  LP_SNOOZE    = 9'(SNOOZE_SEC);
    localparam int          NUM_BTN      = 2;
`else
    localparam int          NUM_BTN      = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_DONE   = 2'd2
`ifdef SNOOZE_EN
        , S_SNOOZE = 2'd3
`endif
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [15:0]   r_tone_cnt;
    logic [15:0]   w_tone_cnt_next;
    logic          r_tone_ph;
    logic          w_tone_ph_next;
    logic [24:0]   r_cad_cnt;
    logic [24:0]   w_cad_cnt_next;
    logic          r_cad_on;
    logic          w_cad_on_next;
    logic [8:0]    r_to_cnt;
    logic [8:0]    w_to_cnt_next;
    logic [8:0]    w_to_inc;
    logic          w_ring_entry;
    logic          r_piezo;
    logic          w_piezo_next;

`ifdef SNOOZE_EN
    logic [8:0]    r_sn_cnt;
    logic [8:0]    w_sn_cnt_next;
    logic [8:0]    w_sn_inc;
`endif

    // Button edge detection: bit 0 is stop, bit 1 (snooze build only) is snooze.
    logic [NUM_BTN-1:0] w_btn;
    logic [NUM_BTN-1:0] w_press;

    assign w_btn[0] = bus.b_stop;
`ifdef SNOOZE_EN
    assign w_btn[1] = bus.b_snooze;
`else
    logic w_unused_snooze;
    assign w_unused_snooze = bus.b_snooze;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic r_prev;
            // Button history, sampled every cycle in every state.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= w_btn[gi];
                end
            end
            assign w_press[gi] = w_btn[gi] & ~r_prev;
        end
    endgenerate

    assign w_to_inc = r_to_cnt + 9'd1;
`ifdef SNOOZE_EN
    assign w_sn_inc = r_sn_cnt + 9'd1;
`endif

    // Next-state logic; stop beats snooze, both beat the timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.hit) begin
                    w_state_next = S_RING;
                end
            end
            S_RING: begin
                if (w_press[0]) begin
                    w_state_next = S_DONE;
                end
`ifdef SNOOZE_EN
                else if (w_press[1]) begin
                    w_state_next = S_SNOOZE;
                end
`endif
                else if (bus.sec_tick && (w_to_inc >= LP_TIMEOUT)) begin
                    w_state_next = S_DONE;
                end
            end
`ifdef SNOOZE_EN
            S_SNOOZE: begin
                if (w_press[0]) begin
                    w_state_next = S_DONE;
                end else if (bus.sec_tick && (w_sn_inc >= LP_SNOOZE)) begin
                    w_state_next = S_RING;
                end
            end
`endif
            S_DONE: begin
                if (!bus.hit) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_ring_entry = (w_state_next == S_RING) && (r_state != S_RING);

    // Tone, cadence and timeout counters; piezo is derived from their next values
    // so that it changes on the same edge as the state.
    always_comb begin
        w_tone_cnt_next = r_tone_cnt;
        w_tone_ph_next  = r_tone_ph;
        w_cad_cnt_next  = r_cad_cnt;
        w_cad_on_next   = r_cad_on;
        w_to_cnt_next   = r_to_cnt;
        if (w_ring_entry) begin
            w_tone_cnt_next = 16'd0;
            w_tone_ph_next  = 1'b1;
            w_cad_cnt_next  = 25'd0;
            w_cad_on_next   = 1'b1;
            w_to_cnt_next   = 9'd0;
        end else if (r_state == S_RING) begin
            if (r_tone_cnt == LP_TONE_LAST) begin
                w_tone_cnt_next = 16'd0;
                w_tone_ph_next  = ~r_tone_ph;
            end else begin
                w_tone_cnt_next = r_tone_cnt + 16'd1;
            end
            if (r_cad_cnt == LP_BEEP_LAST) begin
                w_cad_cnt_next = 25'd0;
                w_cad_on_next  = ~r_cad_on;
            end else begin
                w_cad_cnt_next = r_cad_cnt + 25'd1;
            end
            if (bus.sec_tick) begin
                w_to_cnt_next = w_to_inc;
            end
        end
        w_piezo_next = (w_state_next == S_RING) & w_tone_ph_next & w_cad_on_next;
    end

`ifdef SNOOZE_EN
    // Snooze counter: cleared on entry, counts seconds while snoozing.
    always_comb begin
        w_sn_cnt_next = r_sn_cnt;
        if ((w_state_next == S_SNOOZE) && (r_state != S_SNOOZE)) begin
            w_sn_cnt_next = 9'd0;
        end else if ((r_state == S_SNOOZE) && bus.sec_tick) begin
            w_sn_cnt_next = w_sn_inc;
        end
    end

    // Snooze counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sn_cnt <= 9'd0;
        end else begin
            r_sn_cnt <= w_sn_cnt_next;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter and piezo registers; reset silences the piezo immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tone_cnt <= 16'd0;
            r_tone_ph  <= 1'b0;
            r_cad_cnt  <= 25'd0;
            r_cad_on   <= 1'b0;
            r_to_cnt   <= 9'd0;
            r_piezo    <= 1'b0;
        end else begin
            r_tone_cnt <= w_tone_cnt_next;
            r_tone_ph  <= w_tone_ph_next;
            r_cad_cnt  <= w_cad_cnt_next;
            r_cad_on   <= w_cad_on_next;
            r_to_cnt   <= w_to_cnt_next;
            r_piezo    <= w_piezo_next;
        end
    end

    assign bus.piezo   = r_piezo;
    assign bus.ringing = (r_state == S_RING);
`ifdef SNOOZE_EN
    assign bus.snoozed = (r_state == S_SNOOZE);
`else
    assign bus.snoozed = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sounder.sv
// Directed self-checking bench for alarm_sounder with TONE_HALF=2, BEEP_CYC=8,
// SNOOZE_SEC=3, TIMEOUT_SEC=4 and a sec_tick every 10 cycles. Snooze checks
// follow the SNOOZE_EN macro so the bench matches either build.
module tb_alarm_sounder;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   tick_ph;

    alarm_sounder_if bus ();

    alarm_sounder #(
        .TONE_HALF   (2),
        .BEEP_CYC    (8),
        .SNOOZE_SEC  (3),
        .TIMEOUT_SEC (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected piezo k cycles after RING entry: tone 1,1,0,0 gated by 8 on / 8 off.
    function automatic logic pat(input int k);
        return ((k / 8) % 2 == 0) && ((k % 4) < 2);
    endfunction

    // Advance n clock edges, generating sec_tick on every 10th edge; sample at #1.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            bus.sec_tick = (tick_ph == 9);
            @(posedge clk);
            #1;
            tick_ph = (tick_ph + 1) % 10;
        end
        bus.sec_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        tick_ph      = 0;
        reset        = 1'b0;
        bus.hit      = 1'b0;
        bus.sec_tick = 1'b0;
        bus.b_stop   = 1'b0;
        bus.b_snooze = 1'b0;

        // Reset state
        #1;
        chk("rst_piezo", bus.piezo, 1'b0);
        chk("rst_ringing", bus.ringing, 1'b0);
        chk("rst_snoozed", bus.snoozed, 1'b0);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        chk("idle_ringing", bus.ringing, 1'b0);
        chk("idle_piezo", bus.piezo, 1'b0);

        // Ring pattern followed by timeout after the 4th counted tick (edge 39)
        bus.hit = 1'b1;
        tick_ph = 0;
        for (int k = 0; k < 45; k++) begin
            cyc(1);
            chk($sformatf("ring_ringing_k%0d", k), bus.ringing, (k < 39));
            chk($sformatf("ring_piezo_k%0d", k), bus.piezo, (k < 39) && pat(k));
        end
        cyc(5);
        chk("timeout_hold_ringing", bus.ringing, 1'b0);
        chk("timeout_hold_piezo", bus.piezo, 1'b0);
        bus.hit = 1'b0;
        cyc(1);
        chk("timeout_idle_ringing", bus.ringing, 1'b0);
        bus.hit = 1'b1;
        tick_ph = 0;
        cyc(1);
        chk("rearm_ringing", bus.ringing, 1'b1);
        chk("rearm_piezo", bus.piezo, 1'b1);

        // Stop and re-arm
        cyc(1);
        chk("stop_pre_piezo", bus.piezo, 1'b1);
        bus.b_stop = 1'b1;
        cyc(1);
        chk("stop_piezo", bus.piezo, 1'b0);
        chk("stop_ringing", bus.ringing, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk($sformatf("stop_hold_ringing_%0d", k), bus.ringing, 1'b0);
        end
        bus.b_stop = 1'b0;
        cyc(2);
        chk("stop_hit_high_ringing", bus.ringing, 1'b0);
        bus.hit = 1'b0;
        cyc(1);
        bus.hit = 1'b1;
        tick_ph = 0;
        cyc(1);
        chk("stop_rearm_ringing", bus.ringing, 1'b1);
        chk("stop_rearm_piezo", bus.piezo, 1'b1);

        // Priorities: stop and snooze in the same cycle go to DONE
        bus.b_stop   = 1'b1;
        bus.b_snooze = 1'b1;
        cyc(1);
        chk("both_ringing", bus.ringing, 1'b0);
        chk("both_snoozed", bus.snoozed, 1'b0);
        chk("both_piezo", bus.piezo, 1'b0);
        bus.b_stop   = 1'b0;
        bus.b_snooze = 1'b0;
        bus.hit      = 1'b0;
        cyc(1);
        chk("both_idle_ringing", bus.ringing, 1'b0);

        // Stop held before hit rises has no effect
        bus.b_stop = 1'b1;
        cyc(2);
        bus.hit = 1'b1;
        tick_ph = 0;
        cyc(1);
        chk("held_stop_ringing_k0", bus.ringing, 1'b1);
        chk("held_stop_piezo_k0", bus.piezo, 1'b1);
        for (int k = 1; k < 5; k++) begin
            cyc(1);
            chk($sformatf("held_stop_ringing_k%0d", k), bus.ringing, 1'b1);
            chk($sformatf("held_stop_piezo_k%0d", k), bus.piezo, pat(k));
        end
        bus.b_stop = 1'b0;
        cyc(1);
        chk("held_release_ringing", bus.ringing, 1'b1);
        chk("held_release_piezo", bus.piezo, pat(5));
        bus.hit = 1'b0;
        cyc(1);
        chk("hit_low_ring_ringing", bus.ringing, 1'b1);
        chk("hit_low_ring_piezo", bus.piezo, pat(6));

`ifdef SNOOZE_EN
        // Snooze: three counted ticks return to RING even with hit low
        bus.b_snooze = 1'b1;
        tick_ph = 0;
        cyc(1);
        chk("snz_snoozed_k0", bus.snoozed, 1'b1);
        chk("snz_ringing_k0", bus.ringing, 1'b0);
        chk("snz_piezo_k0", bus.piezo, 1'b0);
        bus.b_snooze = 1'b0;
        for (int k = 1; k < 32; k++) begin
            cyc(1);
            chk($sformatf("snz_snoozed_k%0d", k), bus.snoozed, (k < 29));
            chk($sformatf("snz_ringing_k%0d", k), bus.ringing, (k >= 29));
            chk($sformatf("snz_piezo_k%0d", k), bus.piezo, (k >= 29) && pat(k - 29));
        end
        bus.b_snooze = 1'b1;
        cyc(1);
        chk("snz2_snoozed", bus.snoozed, 1'b1);
        bus.b_snooze = 1'b0;
        cyc(2);
        chk("snz2_hold_snoozed", bus.snoozed, 1'b1);
        bus.b_stop = 1'b1;
        cyc(1);
        chk("snz_stop_snoozed", bus.snoozed, 1'b0);
        chk("snz_stop_ringing", bus.ringing, 1'b0);
        chk("snz_stop_piezo", bus.piezo, 1'b0);
        bus.b_stop = 1'b0;
        cyc(1);
        chk("snz_idle_ringing", bus.ringing, 1'b0);
        chk("snz_idle_snoozed", bus.snoozed, 1'b0);
`else
        // Without snooze support a snooze press leaves the ring running
        bus.b_snooze = 1'b1;
        cyc(1);
        chk("nosnz_ringing", bus.ringing, 1'b1);
        chk("nosnz_snoozed", bus.snoozed, 1'b0);
        bus.b_snooze = 1'b0;
        cyc(1);
        chk("nosnz_ringing2", bus.ringing, 1'b1);
        bus.b_stop = 1'b1;
        cyc(1);
        chk("nosnz_stop_ringing", bus.ringing, 1'b0);
        bus.b_stop = 1'b0;
        cyc(1);
        chk("nosnz_idle_ringing", bus.ringing, 1'b0);
        chk("nosnz_idle_snoozed", bus.snoozed, 1'b0);
`endif

        // Reset mid-ring silences the piezo at once; ring restarts from the top
        bus.hit = 1'b1;
        tick_ph = 0;
        cyc(1);
        chk("rr_pre_piezo", bus.piezo, 1'b1);
        reset = 1'b0;
        #1;
        chk("rr_async_piezo", bus.piezo, 1'b0);
        chk("rr_async_ringing", bus.ringing, 1'b0);
        cyc(1);
        chk("rr_held_ringing", bus.ringing, 1'b0);
        reset = 1'b1;
        tick_ph = 0;
        cyc(1);
        chk("rr_restart_ringing", bus.ringing, 1'b1);
        chk("rr_restart_piezo", bus.piezo, 1'b1);
        for (int k = 1; k < 10; k++) begin
            cyc(1);
            chk($sformatf("rr_ringing_k%0d", k), bus.ringing, 1'b1);
            chk($sformatf("rr_piezo_k%0d", k), bus.piezo, pat(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_sounder.md
# alarm_sounder

Consumes the level-sensitive alarm-match signal produced by the alarm-time comparator and turns it into an audible piezo drive. It generates a gated square-wave tone with an on/off beep cadence and handles user stop and snooze presses. Ringing auto-stops after a timeout. The block sits between the alarm/time logic and the board's piezo pin, and uses the clock block's 1 Hz tick for second-based timing.

## Interface
- TONE_HALF, 12500: clk cycles per tone half-period (2 kHz at 50 MHz); range 1..65535.
- BEEP_CYC, 25000000: clk cycles per cadence half (0.5 s on, 0.5 s off); range 1..2^25-1.
- SNOOZE_SEC, 300: snooze length in sec_tick pulses; range 1..511.
- TIMEOUT_SEC, 60: maximum continuous ring length in sec_tick pulses; range 1..511.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- hit  in  1  alarm match level; high while current time equals alarm time and the alarm is enabled.
- sec_tick  in  1  one-cycle pulse, once per second.
- b_stop  in  1  stop button, level, synchronous to clk.
- b_snooze  in  1  snooze button, level, synchronous to clk.
- piezo  out  1  registered tone drive.
- ringing  out  1  high while the FSM is in RING.
- snoozed  out  1  high while the FSM is in SNOOZE.

## Operation
- FSM states: IDLE, RING, SNOOZE, DONE. Reset puts the FSM in IDLE and drives piezo, ringing and snoozed to 0. All counters clear to 0 and all button history registers clear to 0.
- Button presses are rising edges only: press = b & ~b_prev, where b_prev is registered every cycle in every state. A button held since before RING is entered causes no action.
- **IDLE**
  - hit=1 → RING.
- **RING**
  - b_stop press → DONE.
  - Otherwise b_snooze press → SNOOZE. Stop wins when both are pressed in the same cycle.
  - Otherwise timeout count reaching TIMEOUT_SEC → DONE.
- **SNOOZE**
  - b_stop press → DONE.
  - Otherwise the snooze count reaching SNOOZE_SEC → RING, regardless of hit.
- **DONE**
  - hit=0 → IDLE. Re-arming requires hit to fall, so the same match minute never re-rings after stop or timeout.
- **Entry into RING** (from IDLE or SNOOZE) clears the tone counter, cadence counter and timeout counter. It sets the tone phase to 1 and the cadence phase to "on".
- **Tone counter**
  - Counts 0..TONE_HALF-1 every cycle in RING.
  - At terminal count it wraps to 0 and the tone phase toggles.
- **Cadence counter**
  - Counts 0..BEEP_CYC-1 every cycle in RING.
  - At terminal count it wraps and the cadence phase toggles.
  - The tone counter keeps running during the off phase.
- **Timeout counter**
  - 9 bits; increments on sec_tick while in RING.
  - Compared against TIMEOUT_SEC after the increment.
- **Snooze counter**
  - 9 bits; cleared on entry to SNOOZE; increments on sec_tick while in SNOOZE.
- **Outputs**
  - piezo = (next state is RING) & tone phase & cadence "on".
  - piezo is 0 in every other state.
- hit is ignored in RING and SNOOZE. A ring continues after hit falls until stop or timeout.

## Timing
- State change, counter clear and output update all occur on the same clk edge, with no extra pipeline stage.
- IDLE→RING takes effect on the edge that first samples hit=1. piezo=1 and ringing=1 in the following cycle.
- A button press takes effect on the edge that first samples the button high. piezo=0 from the next cycle.
- A sec_tick arriving in the same cycle as a transition into RING or SNOOZE is not counted.
- Reset asserted mid-ring forces piezo=0 asynchronously. If hit is still 1 after reset release, ringing restarts on the next edge.

## Configuration
- SNOOZE_EN defined: the snooze behaviour is as described above.
- SNOOZE_EN undefined:
  - b_snooze is ignored; the port remains present.
  - The SNOOZE state and snooze counter are not built.
  - snoozed is tied to 0.
  - RING exits only via stop or timeout.

All test scenarios use TONE_HALF=2, BEEP_CYC=8, SNOOZE_SEC=3, TIMEOUT_SEC=4, with sec_tick every 10 cycles.

## Test plan
- **Ring pattern:** raise hit and hold it. → ringing=1 the next cycle. piezo repeats 1,1,0,0,1,1,0,0 followed by 8 cycles of 0, and the pattern recurs.
- **Stop and re-arm:** b_stop rising during RING. → piezo=0 and ringing=0 next cycle. Holding hit=1 gives no re-ring. Dropping hit for 1 cycle and then raising it again starts a fresh ring.
- **Timeout:** hold hit=1 with no buttons. → DONE after the 4th sec_tick counted in RING, with piezo=0 thereafter.
- **Snooze:** b_snooze rising, with SNOOZE_EN defined. → snoozed=1 and piezo=0. After 3 counted sec_ticks, ringing=1 even with hit=0. A stop press during SNOOZE goes to DONE.
- **Priorities:** b_stop and b_snooze rising in the same cycle → DONE. A b_stop held high before hit rises → no effect, and RING continues.
- **Reset mid-ring:** assert reset during piezo=1. → piezo=0 immediately. Release with hit=1 → ringing restarts with the pattern from its start.
